serial_neq_cmp: RTL and testbench
=================================

# serial_neq_cmp

Bit-serial inequality comparator. It accepts two WIDTH-bit operands on a start strobe and shifts them out LSB-first, one bit pair per clock. It accumulates any mismatch and reports the a_neq_b result with a one-cycle done pulse. It is the sequential, area-reduced counterpart of the combinational 6-bit inequality stage. Its a_neq_b/done pair feeds the same downstream result logic.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; honoured only in IDLE.
- a  in  WIDTH  operand A; sampled only on the accepted start edge.
- b  in  WIDTH  operand B; sampled only on the accepted start edge.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; result valid.
- a_neq_b  out  1  1 if a != b for the last completed compare; held until the next done.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. Encoding is binary, 2 bits.
- IDLE, start=1:
  - load a_sr<=a and b_sr<=b;
  - clear diff<=0 and cnt<=0;
  - go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - diff <= diff | (a_sr[0]^b_sr[0]);
  - shift both registers right, zero-filled;
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- DONE:
  - done=1;
  - a_neq_b is already loaded from the final diff on the SHIFT->DONE edge;
  - unconditionally go to IDLE.
- cnt width is clog2(WIDTH). It never wraps, because it is cleared on every accepted start.
- start in SHIFT or DONE is ignored. It is not queued, and operands are not resampled.
- Changes on a or b after acceptance have no effect on the running compare.
- a_neq_b is registered. It changes only on the edge that enters DONE.

## Timing
- Reset values:
  - state=IDLE;
  - busy=0, done=0, a_neq_b=0;
  - a_sr=0, b_sr=0, diff=0, cnt=0.
- rst has priority over all other inputs on the same edge.
- rst during SHIFT or DONE aborts the compare. No done pulse is produced, and a_neq_b returns to 0.
- Call the accepting start edge E0.
- busy is high in the cycles after edges E0 through E0+WIDTH-1, i.e. WIDTH cycles.
- done and the new a_neq_b are visible after edge E0+WIDTH.
- done is high for exactly one cycle. busy is low in the DONE cycle.
- Earliest next accepted start is edge E0+WIDTH+2, because start at E0+WIDTH+1 is sampled in DONE and ignored. Throughput is one compare per WIDTH+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: SERIAL_NEQ_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, a differing bit pair at bit index i transitions to DONE on that same edge, with a_neq_b<=1.
  - done appears after edge E0+i+1.
  - Equal operands still take the full WIDTH cycles.
- Undefined:
  - Latency is fixed at WIDTH+1 edges regardless of data; no data-dependent timing.
- Both builds produce identical a_neq_b values for every operand pair.

## Structure
- The shared package serial_cmp_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE) and its encoding constants;
  - default CMP_WIDTH=6;
  - a clog2-based CNT_W helper constant.
- One sub-module, piso_shift, is natural:
  - a WIDTH-bit parallel-load, right-shift register with load/shift enables and serial LSB output;
  - it is instantiated twice, for A and B.
- The FSM, counter and diff accumulator live in the top.

## Test plan
- Reset mid-compare: start with a=6'b101010, b=6'b010101, rst at E0+3 -> no done pulse ever; busy=0 and a_neq_b=0 the cycle after rst.
- Equal operands: a=b=6'b111000 -> busy high 6 cycles, done after E0+6, a_neq_b=0, in both macro builds.
- MSB-only mismatch: a=6'b100000, b=6'b000000 -> a_neq_b=1, done after E0+6, in both builds.
- LSB mismatch, a=6'b000001, b=6'b000000:
  - macro undefined -> done after E0+6, a_neq_b=1;
  - macro defined -> done after E0+1, a_neq_b=1.
- Start during busy: accept a=3,b=3; at E0+2 drive start with a=5,b=9 -> ignored; result a_neq_b=0; exactly one done pulse.
- Exhaustive sweep of all 4096 pairs, each compare launched at the earliest legal start -> a_neq_b==(a!=b) every time; done count 4096.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial comparator family.
// FSM state encoding, default operand width and the counter width helper.
package serial_cmp_pkg;

    localparam int CMP_WIDTH = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Counter must hold 0..w-1; at least one bit even for the smallest width.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_w(CMP_WIDTH);

endpackage

// File: rtl/serial_neq_cmp_if.sv
// Request/result bundle of the serial inequality comparator.
// The master issues start with operands; the slave returns busy, done and a_neq_b.
interface serial_neq_cmp_if
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_neq_b;

    modport master (output start, a, b, input busy, done, a_neq_b);
    modport slave  (input start, a, b, output busy, done, a_neq_b);
endinterface

// File: rtl/piso_shift.sv
// Parallel-load, right-shift register presenting its LSB serially.
// Load has priority over shift; vacated MSBs fill with zero.
module piso_shift #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb
);
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign w_next[gi] = 1'b0;
            end else begin : g_mid
                assign w_next[gi] = r_sr[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= w_next;
        end
    end

    assign o_lsb = r_sr[0];
endmodule

// File: rtl/serial_neq_cmp.sv
// Bit-serial inequality comparator: operands shift out LSB-first, mismatches accumulate.
// Define SERIAL_NEQ_EARLY_EXIT_EN to finish on the first differing bit pair.
module serial_neq_cmp
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_neq_cmp_if.slave    bus
);
    localparam int CNT_WL = cnt_w(WIDTH);
    localparam logic [CNT_WL-1:0] LAST_CNT = CNT_WL'(WIDTH - 1);

    state_t            r_state;
    logic [CNT_WL-1:0] r_cnt;
    logic              r_diff;
    logic              r_busy;
    logic              r_done;
    logic              r_neq;

    logic w_load;
    logic w_shift;
    logic w_a_bit;
    logic w_b_bit;
    logic w_bit_diff;

    assign w_load     = (r_state == ST_IDLE) && bus.start;
    assign w_shift    = (r_state == ST_SHIFT);
    assign w_bit_diff = w_a_bit ^ w_b_bit;

    piso_shift #(.WIDTH(WIDTH)) u_a_sr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (bus.a),
        .o_lsb   (w_a_bit)
    );

    piso_shift #(.WIDTH(WIDTH)) u_b_sr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (bus.b),
        .o_lsb   (w_b_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_diff  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neq   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_cnt   <= '0;
                        r_diff  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_diff <= r_diff | w_bit_diff;
                    r_cnt  <= r_cnt + 1'b1;
`ifdef SERIAL_NEQ_EARLY_EXIT_EN
                    if (w_bit_diff) begin
                        r_neq   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_neq   <= r_diff;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
`else
                    // Result is captured with the last bit pair folded in.
                    if (r_cnt == LAST_CNT) begin
                        r_neq   <= r_diff | w_bit_diff;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.a_neq_b = r_neq;
endmodule

// File: tb/tb_serial_neq_cmp.sv
// Self-checking bench for serial_neq_cmp: per-cycle busy/done/result checks plus
// a result scoreboard filled at start acceptance and drained on each done pulse.
module tb_serial_neq_cmp;
    localparam int W = 6;

    logic clk;
    logic rst;

    serial_neq_cmp_if #(.WIDTH(W)) bus ();

    serial_neq_cmp #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   exp_dones = 0;
    logic model_neq = 1'b0;
    logic exp_q[$];

    function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SERIAL_NEQ_EARLY_EXIT_EN
        for (int i = 0; i < W; i++) begin
            if (av[i] != bv[i]) return i + 1;
        end
`endif
        return W;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard drain: every done pulse must match the oldest accepted compare.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done a_neq_b=%b expected no done", bus.a_neq_b);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (bus.a_neq_b !== e) begin
                    failures++;
                    if (failures < 40)
                        $display("FAIL sb_result a_neq_b=%b expected=%b", bus.a_neq_b, e);
                end
            end
        end
    end

    // One compare from acceptance to the IDLE cycle after DONE; inj>0 re-strobes start at E0+inj.
    task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input int inj, input string name);
        logic e;
        int   lat;
        e   = (av != bv);
        lat = exp_lat(av, bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        step();
        exp_q.push_back(e);
        exp_dones++;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                if (k == inj) begin
                    bus.start = 1'b1;
                    bus.a     = 6'd5;
                    bus.b     = 6'd9;
                end else begin
                    bus.start = 1'b0;
                end
                step();
            end
            checks++;
            if (bus.busy !== (k < lat) || bus.done !== (k == lat) ||
                bus.a_neq_b !== ((k == lat) ? e : model_neq)) begin
                failures++;
                if (failures < 40)
                    $display("FAIL %s cyc=%0d a=%0d b=%0d busy/done/neq=%b%b%b expected=%b%b%b",
                             name, k, av, bv, bus.busy, bus.done, bus.a_neq_b,
                             (k < lat), (k == lat), ((k == lat) ? e : model_neq));
            end
        end
        model_neq = e;
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.a_neq_b !== e) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s_after_done busy/done/neq=%b%b%b expected=00%b",
                         name, bus.busy, bus.done, bus.a_neq_b, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.a_neq_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy/done/neq=%b%b%b expected=000", bus.busy, bus.done, bus.a_neq_b);
        end
        rst = 1'b0;
        model_neq = 1'b0;
        step();
    endtask

    task automatic test_lsb_mismatch();
        run_cmp(6'b000001, 6'b000000, -1, "lsb_mismatch");
    endtask

    task automatic test_reset_mid();
        int d0;
        bus.start = 1'b1;
        bus.a = 6'b101010;
        bus.b = 6'b010101;
        step();
        bus.start = 1'b0;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy busy=%b expected=1", bus.busy);
        end
        d0 = done_cnt;
        rst = 1'b1;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.a_neq_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort busy/done/neq=%b%b%b expected=000", bus.busy, bus.done, bus.a_neq_b);
        end
        rst = 1'b0;
        model_neq = 1'b0;
        repeat (12) step();
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL reset_mid_no_done dones=%0d expected=0", done_cnt - d0);
        end
    endtask

    task automatic test_equal();
        run_cmp(6'b111000, 6'b111000, -1, "equal");
    endtask

    task automatic test_msb_mismatch();
        run_cmp(6'b100000, 6'b000000, -1, "msb_mismatch");
    endtask

    task automatic test_start_during_busy();
        int d0;
        d0 = done_cnt;
        run_cmp(6'd3, 6'd3, 2, "start_busy");
        repeat (W + 3) step();
        checks++;
        if (done_cnt - d0 != 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL start_busy_single dones=%0d busy=%b expected dones=1 busy=0", done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_sweep();
        int d0;
        d0 = done_cnt;
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                run_cmp(W'(x), W'(y), -1, "sweep");
            end
        end
        step();
        checks++;
        if (done_cnt - d0 != 4096) begin
            failures++;
            $display("FAIL sweep_done_count dones=%0d expected=4096", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_mismatch();
        test_reset_mid();
        test_equal();
        test_msb_mismatch();
        test_lsb_mismatch();
        test_start_during_busy();
        test_sweep();
        repeat (3) step();
        checks++;
        if (done_cnt != exp_dones || exp_q.size() != 0) begin
            failures++;
            $display("FAIL total_dones dones=%0d pending=%0d expected dones=%0d pending=0",
                     done_cnt, exp_q.size(), exp_dones);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
